// File: rtl/tempo_pkg.sv
// Shared constants and saturating step arithmetic for the tempo controller.
// Latency: n/a (package only).
// Backpressure: n/a.
package tempo_pkg;

    // Default timing at a 25 MHz clock: 10 ms debounce, 0.5 s repeat delay, 100 ms repeat rate.
    localparam int DEBOUNCE_CYC_DEF     = 250000;
    localparam int REPEAT_DELAY_CYC_DEF = 12500000;
    localparam int REPEAT_RATE_CYC_DEF  = 2500000;

    localparam logic [7:0] BPM_MIN     = 8'd30;
    localparam logic [7:0] BPM_MAX     = 8'd240;
    localparam logic [7:0] BPM_INIT    = 8'd60;
    localparam logic [7:0] STEP_FINE   = 8'd1;
    localparam logic [7:0] STEP_COARSE = 8'd10;

    // Button index, listed in arbitration priority order (highest first).
    typedef enum logic [1:0] {
        BTN_LEFT  = 2'd0,
        BTN_RIGHT = 2'd1,
        BTN_DOWN  = 2'd2,
        BTN_UP    = 2'd3
    } btn_e;

    // Step cur by +/-step in 9 bits; a borrow or an out-of-range result clamps.
    function automatic logic [7:0] sat_step(input logic [7:0] cur,
                                            input logic [7:0] step,
                                            input logic       dec);
        logic [8:0] sum;
        logic [7:0] res;
        if (dec) begin
            sum = {1'b0, cur} - {1'b0, step};
            res = (sum[8] || (sum[7:0] < BPM_MIN)) ? BPM_MIN : sum[7:0];
        end else begin
            sum = {1'b0, cur} + {1'b0, step};
            res = (sum > {1'b0, BPM_MAX}) ? BPM_MAX : sum[7:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/tempo_ctrl_if.sv
// Front-panel bundle: four raw buttons in, current tempo and change strobe out.
// Latency: n/a (wires only).
// Backpressure: none; speed is a level, speed_upd a one-cycle strobe.
interface tempo_ctrl_if;
    logic       left;
    logic       right;
    logic       down;
    logic       up;
    logic [7:0] speed;
    logic       speed_upd;

    // master: the panel/test side driving buttons
    modport master (output left, right, down, up, input speed, speed_upd);
    // slave: the tempo controller
    modport slave  (input left, right, down, up, output speed, speed_upd);
endinterface

// File: rtl/btn_cond.sv
// One button: 2-FF sync, counter debounce, press one-shot and auto-repeat -> evt pulse.
// Latency: raw edge to evt = 2 + DEBOUNCE_CYC cycles; repeats at +REPEAT_DELAY_CYC, then every REPEAT_RATE_CYC.
// Backpressure: none; evt is a single-cycle pulse and is lost if not consumed.
// Ports: clk, rst (sync, active-high), raw (asynchronous button), evt (registered pulse).
module btn_cond #(
    parameter int DEBOUNCE_CYC     = 4,
    parameter int REPEAT_DELAY_CYC = 20,
    parameter int REPEAT_RATE_CYC  = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic evt
);
    localparam int DW   = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int RMAX = (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ? REPEAT_DELAY_CYC : REPEAT_RATE_CYC;
    localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

    localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYC - 1);
    localparam logic [RW-1:0] RPT_FIRST  = RW'(REPEAT_DELAY_CYC - 1);
    localparam logic [RW-1:0] RPT_NEXT   = RW'(REPEAT_RATE_CYC - 1);

    logic          sync1;
    logic          sync2;
    logic          deb;
    logic [DW-1:0] cnt;
    logic [RW-1:0] rpt;
    logic          first;
    logic [1:0]    warm;
    logic          armed;
    logic          flip;

    assign flip = (sync2 != deb) && (cnt == DB_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            deb   <= 1'b0;
            cnt   <= '0;
            rpt   <= '0;
            first <= 1'b1;
            warm  <= 2'b00;
            armed <= 1'b0;
            evt   <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            warm  <= {warm[0], 1'b1};
            evt   <= 1'b0;

            // A button held through reset must be seen released before it can
            // fire again; warm waits until sync2 carries a real post-reset sample.
            if (!armed && warm[1] && !sync2 && !deb) begin
                armed <= 1'b1;
            end

            if (sync2 == deb) begin
                cnt <= '0;
            end else if (!flip) begin
                cnt <= cnt + DW'(1);
            end else begin
                cnt <= '0;
            end

            if (flip) begin
                deb   <= sync2;
                rpt   <= '0;
                first <= 1'b1;
                evt   <= sync2 & armed;
            end else if (deb) begin
                if (first ? (rpt == RPT_FIRST) : (rpt == RPT_NEXT)) begin
                    evt   <= armed;
                    rpt   <= '0;
                    first <= 1'b0;
                end else begin
                    rpt <= rpt + RW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/tempo_ctrl.sv
// Tempo controller: four conditioned buttons, fixed-priority arbiter, saturating BPM register.
// Latency: button event to speed/speed_upd is one clock.
// Backpressure: none; simultaneous lower-priority events are dropped.
// Ports: clk, rst (sync, active-high), bus (slave: left/right/down/up in, speed/speed_upd out).
module tempo_ctrl
    import tempo_pkg::*;
#(
    parameter int DEBOUNCE_CYC     = DEBOUNCE_CYC_DEF,
    parameter int REPEAT_DELAY_CYC = REPEAT_DELAY_CYC_DEF,
    parameter int REPEAT_RATE_CYC  = REPEAT_RATE_CYC_DEF
) (
    input  logic         clk,
    input  logic         rst,
    tempo_ctrl_if.slave  bus
);
    logic [3:0] evt;
    logic [3:0] raw;
    logic [7:0] speed;
    logic       speed_upd;
    logic       step_vld;
    logic       step_dec;
    logic [7:0] step;
    logic [7:0] speed_nxt;

    assign raw[BTN_LEFT]  = bus.left;
    assign raw[BTN_RIGHT] = bus.right;
    assign raw[BTN_DOWN]  = bus.down;
    assign raw[BTN_UP]    = bus.up;

    for (genvar i = 0; i < 4; i++) begin : g_btn
        btn_cond #(
            .DEBOUNCE_CYC     (DEBOUNCE_CYC),
            .REPEAT_DELAY_CYC (REPEAT_DELAY_CYC),
            .REPEAT_RATE_CYC  (REPEAT_RATE_CYC)
        ) u_btn (
            .clk (clk),
            .rst (rst),
            .raw (raw[i]),
            .evt (evt[i])
        );
    end

    // Fixed priority: left > right > down > up.
    always_comb begin
        step_vld = 1'b1;
        step_dec = 1'b0;
        step     = STEP_FINE;
        if (evt[BTN_LEFT]) begin
            step_dec = 1'b1;
        end else if (evt[BTN_RIGHT]) begin
            step_dec = 1'b0;
        end else if (evt[BTN_DOWN]) begin
            step_dec = 1'b1;
            step     = STEP_COARSE;
        end else if (evt[BTN_UP]) begin
            step     = STEP_COARSE;
        end else begin
            step_vld = 1'b0;
        end
        speed_nxt = sat_step(speed, step, step_dec);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            speed     <= BPM_INIT;
            speed_upd <= 1'b0;
        end else begin
            speed_upd <= 1'b0;
            if (step_vld) begin
                speed     <= speed_nxt;
                speed_upd <= (speed_nxt != speed);
            end
        end
    end

    assign bus.speed     = speed;
    assign bus.speed_upd = speed_upd;

endmodule

// File: tb/tb_tempo_ctrl.sv
// Bench for tempo_ctrl: directed scenarios with literal expectations plus random button
// traffic, all checked every cycle against a behavioural model of the front panel.
module tb_tempo_ctrl;
    localparam int DB   = 4;
    localparam int DLY  = 20;
    localparam int RATE = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tempo_ctrl_if bus();

    tempo_ctrl #(
        .DEBOUNCE_CYC     (DB),
        .REPEAT_DELAY_CYC (DLY),
        .REPEAT_RATE_CYC  (RATE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    int upd_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Per button: the raw level sampled at the last 5 edges (index 0 = newest),
    // debounced level, armed flag, and time since the press.
    bit m_r[4][5];
    bit m_deb[4];
    bit m_arm[4];
    int m_tp[4];
    bit m_pend[4];
    int m_speed = 60;
    bit m_upd   = 1'b0;
    int m_n     = 0;
    bit m_valid = 1'b0;

    task automatic model_step();
        bit raw[4];
        bit ev[4];
        bit seen;
        bit all_diff;
        bit arm_pre;
        int delta;
        int nv;
        raw = '{bus.left, bus.right, bus.down, bus.up};
        if (rst) begin
            for (int b = 0; b < 4; b++) begin
                for (int j = 0; j < 5; j++) m_r[b][j] = 1'b0;
                m_deb[b] = 1'b0; m_arm[b] = 1'b0; m_tp[b] = 0; m_pend[b] = 1'b0;
            end
            m_speed = 60; m_upd = 1'b0; m_n = 0; m_valid = 1'b1;
        end else begin
            m_n++;
            // apply the event chosen at the previous edge
            delta = 0;
            if (m_pend[0])      delta = -1;
            else if (m_pend[1]) delta = 1;
            else if (m_pend[2]) delta = -10;
            else if (m_pend[3]) delta = 10;
            m_upd = 1'b0;
            if (m_pend[0] || m_pend[1] || m_pend[2] || m_pend[3]) begin
                nv = m_speed + delta;
                if (nv < 30)  nv = 30;
                if (nv > 240) nv = 240;
                m_upd = (nv != m_speed);
                m_speed = nv;
            end
            for (int b = 0; b < 4; b++) begin
                ev[b] = 1'b0;
                // the synchroniser shows the raw level from two edges back
                seen = m_r[b][1];
                arm_pre = m_arm[b];
                if (!m_arm[b] && m_n >= 3 && !seen && !m_deb[b]) m_arm[b] = 1'b1;
                all_diff = (m_r[b][1] != m_deb[b]) && (m_r[b][2] != m_deb[b]) &&
                           (m_r[b][3] != m_deb[b]) && (m_r[b][4] != m_deb[b]);
                if (all_diff) begin
                    m_deb[b] = ~m_deb[b];
                    if (m_deb[b]) begin
                        m_tp[b] = 0;
                        ev[b] = arm_pre;
                    end
                end else if (m_deb[b]) begin
                    m_tp[b]++;
                    if (m_tp[b] == DLY || (m_tp[b] > DLY && ((m_tp[b] - DLY) % RATE) == 0))
                        ev[b] = arm_pre;
                end
                for (int j = 4; j > 0; j--) m_r[b][j] = m_r[b][j-1];
                m_r[b][0] = raw[b];
            end
            m_pend = ev;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Per-cycle comparison and pulse counting, away from the active edge.
    initial forever begin
        @(negedge clk);
        if (bus.speed_upd === 1'b1) upd_cnt++;
        if (m_valid) begin
            check("speed", int'(bus.speed), m_speed);
            check("speed_upd", int'(bus.speed_upd), int'(m_upd));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_btn(input int b, input bit v);
        case (b)
            0: bus.left  = v;
            1: bus.right = v;
            2: bus.down  = v;
            default: bus.up = v;
        endcase
    endtask

    task automatic press(input int b);
        set_btn(b, 1'b1);
        tick(8);
        set_btn(b, 1'b0);
        tick(12);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(5);
    endtask

    int c0;
    int lat;
    int lvl[4];
    int rem[4];

    initial begin
        bus.left = 1'b0; bus.right = 1'b0; bus.down = 1'b0; bus.up = 1'b0;
        rst = 1'b1;
        tick(3);
        rst = 1'b0;

        // 1: idle after reset
        tick(50);
        check("t1_speed", int'(bus.speed), 60);
        check("t1_upd_pulses", upd_cnt, 0);

        // 2: single fine step, latency, then a short glitch
        c0 = upd_cnt;
        lat = -1;
        bus.right = 1'b1;
        for (int i = 1; i <= 20 && lat < 0; i++) begin
            tick(1);
            if (bus.speed_upd === 1'b1) lat = i;
        end
        check("t2_latency", lat, 7);
        tick(3);
        bus.right = 1'b0;
        tick(15);
        check("t2_speed", int'(bus.speed), 61);
        check("t2_pulses", upd_cnt - c0, 1);
        bus.left = 1'b1;
        tick(3);
        bus.left = 1'b0;
        tick(15);
        check("t2_glitch_speed", int'(bus.speed), 61);

        // 3: up held through repeats to saturation
        do_reset();
        c0 = upd_cnt;
        bus.up = 1'b1;
        tick(120);
        bus.up = 1'b0;
        tick(15);
        check("t3_speed", int'(bus.speed), 240);
        check("t3_pulses", upd_cnt - c0, 18);

        // 4: lower saturation, no-op steps carry no strobe
        do_reset();
        press(2); press(2);
        for (int i = 0; i < 5; i++) press(0);
        check("t4_start", int'(bus.speed), 35);
        press(2);
        check("t4_first_down", int'(bus.speed), 30);
        c0 = upd_cnt;
        press(2);
        check("t4_second_down", int'(bus.speed), 30);
        press(0);
        check("t4_left", int'(bus.speed), 30);
        check("t4_no_pulse", upd_cnt - c0, 0);

        // 5: left and right together, left wins
        do_reset();
        for (int i = 0; i < 4; i++) press(3);
        check("t5_start", int'(bus.speed), 100);
        c0 = upd_cnt;
        bus.left = 1'b1; bus.right = 1'b1;
        tick(10);
        bus.left = 1'b0; bus.right = 1'b0;
        tick(12);
        check("t5_speed", int'(bus.speed), 99);
        check("t5_pulses", upd_cnt - c0, 1);

        // 6: reset while up is held
        do_reset();
        bus.up = 1'b1;
        tick(40);
        check("t6_before", int'(bus.speed), 100);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        c0 = upd_cnt;
        tick(60);
        check("t6_after_rst", int'(bus.speed), 60);
        check("t6_no_pulse", upd_cnt - c0, 0);
        bus.up = 1'b0;
        tick(15);
        press(3);
        check("t6_repress", int'(bus.speed), 70);

        // random traffic: mixed glitches, presses and long holds, rare resets
        for (int b = 0; b < 4; b++) begin lvl[b] = 0; rem[b] = 1; end
        for (int cyc = 0; cyc < 4000; cyc++) begin
            for (int b = 0; b < 4; b++) begin
                rem[b]--;
                if (rem[b] <= 0) begin
                    lvl[b] = 1 - lvl[b];
                    if ($urandom_range(0, 2) == 0) rem[b] = $urandom_range(1, 5);
                    else if (lvl[b] == 1)          rem[b] = $urandom_range(6, 60);
                    else                           rem[b] = $urandom_range(6, 120);
                end
                set_btn(b, lvl[b][0]);
            end
            rst = ($urandom_range(0, 699) == 0);
            tick(1);
        end
        rst = 1'b0;
        bus.left = 1'b0; bus.right = 1'b0; bus.down = 1'b0; bus.up = 1'b0;
        tick(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
